// File: rtl/axi4_port_arbiter_if.sv
// AXI4 master-port bundle between the port arbiter and the memory side.
// The arbiter uses the master modport; a memory model or interconnect uses slave.
interface axi4_port_arbiter_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [AddrWidth-1:0]     awaddr;
    logic [7:0]               awlen;
    logic                     wvalid;
    logic                     wready;
    logic [DataWidth-1:0]     wdata;
    logic [DataWidth/8-1:0]   wstrb;
    logic                     wlast;
    logic                     bvalid;
    logic                     bready;
    logic                     arvalid;
    logic                     arready;
    logic [AddrWidth-1:0]     araddr;
    logic [7:0]               arlen;
    logic                     rvalid;
    logic                     rready;
    logic [DataWidth-1:0]     rdata;
    logic                     rlast;

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/axi4_port_arbiter.sv
// Shares one AXI4 master port between NUM_REQ requesters with independent
// round-robin read and write arbiters, one outstanding burst per direction.
module axi4_port_arbiter #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ            = 4
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    // Read requesters
    input  logic [NUM_REQ-1:0]                     rd_req_valid_i,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]  rd_req_addr_i,
    input  logic [NUM_REQ*8-1:0]                   rd_req_len_i,
    output logic [NUM_REQ-1:0]                     rd_req_ready_o,
    output logic [C_M_AXI_DATA_WIDTH-1:0]          rd_data_o,
    output logic [NUM_REQ-1:0]                     rd_data_valid_o,
    output logic                                   rd_data_last_o,
    input  logic [NUM_REQ-1:0]                     rd_data_ready_i,
    // Write requesters
    input  logic [NUM_REQ-1:0]                     wr_req_valid_i,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]  wr_req_addr_i,
    input  logic [NUM_REQ*8-1:0]                   wr_req_len_i,
    output logic [NUM_REQ-1:0]                     wr_req_ready_o,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]  wr_data_i,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH/8-1:0] wr_strb_i,
    input  logic [NUM_REQ-1:0]                     wr_data_valid_i,
    output logic [NUM_REQ-1:0]                     wr_data_ready_o,
    output logic [NUM_REQ-1:0]                     wr_done_o,
    // Shared AXI4 master port
    axi4_port_arbiter_if.master                    m_axi
);

    localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CandW = IdxW + 1;

    // First requesting index at or after ptr, wrapping; only used when req != 0.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IdxW-1:0]    ptr);
        logic [IdxW-1:0]  pick;
        logic             found;
        logic [CandW-1:0] cand;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + CandW'(i);
            if (cand >= CandW'(NUM_REQ)) begin
                cand = cand - CandW'(NUM_REQ);
            end
            if (!found && req[cand[IdxW-1:0]]) begin
                pick  = cand[IdxW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] g);
        return (g == IdxW'(NUM_REQ - 1)) ? '0 : g + IdxW'(1);
    endfunction

    // ---------------------------------------------------------------- read side
    typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;

    rd_state_e       rd_state_q, rd_state_d;
    logic [IdxW-1:0] rd_owner_q, rd_owner_d;
    logic [IdxW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]      rd_len_q, rd_len_d;
    logic [IdxW-1:0] rd_pick;
    logic            ar_valid;
    logic            r_ready;

    assign rd_pick = rr_pick(rd_req_valid_i, rd_ptr_q);

    always_comb begin
        rd_state_d      = rd_state_q;
        rd_owner_d      = rd_owner_q;
        rd_ptr_d        = rd_ptr_q;
        rd_addr_d       = rd_addr_q;
        rd_len_d        = rd_len_q;
        rd_req_ready_o  = '0;
        rd_data_valid_o = '0;
        rd_data_o       = '0;
        rd_data_last_o  = 1'b0;
        ar_valid        = 1'b0;
        r_ready         = 1'b0;
        unique case (rd_state_q)
            RIdle: begin
                if (|rd_req_valid_i) begin
                    rd_req_ready_o[rd_pick] = 1'b1;
                    rd_owner_d              = rd_pick;
                    rd_addr_d               = rd_req_addr_i[rd_pick*AW +: AW];
                    rd_len_d                = rd_req_len_i[rd_pick*8 +: 8];
                    rd_ptr_d                = rr_next(rd_pick);
                    rd_state_d              = RAddr;
                end
            end
            RAddr: begin
                ar_valid = 1'b1;
                if (m_axi.arready) begin
                    rd_state_d = RData;
                end
            end
            RData: begin
                r_ready                     = rd_data_ready_i[rd_owner_q];
                rd_data_valid_o[rd_owner_q] = m_axi.rvalid;
                rd_data_o                   = m_axi.rdata;
                rd_data_last_o              = m_axi.rlast;
                if (m_axi.rvalid && r_ready && m_axi.rlast) begin
                    rd_state_d = RIdle;
                end
            end
            default: rd_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= RIdle;
            rd_owner_q <= '0;
            rd_ptr_q   <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_owner_q <= rd_owner_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
        end
    end

    assign m_axi.arvalid = ar_valid;
    assign m_axi.araddr  = rd_addr_q;
    assign m_axi.arlen   = rd_len_q;
    assign m_axi.rready  = r_ready;

    // --------------------------------------------------------------- write side
    typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} wr_state_e;

    wr_state_e       wr_state_q, wr_state_d;
    logic [IdxW-1:0] wr_owner_q, wr_owner_d;
    logic [IdxW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_len_q, wr_len_d;
    logic [7:0]      wr_cnt_q, wr_cnt_d;
    logic [IdxW-1:0] wr_pick;
    logic            aw_valid;
    logic            w_valid;
    logic [DW-1:0]   w_data;
    logic [SW-1:0]   w_strb;
    logic            w_last;
    logic            b_ready;

    assign wr_pick = rr_pick(wr_req_valid_i, wr_ptr_q);

    always_comb begin
        wr_state_d      = wr_state_q;
        wr_owner_d      = wr_owner_q;
        wr_ptr_d        = wr_ptr_q;
        wr_addr_d       = wr_addr_q;
        wr_len_d        = wr_len_q;
        wr_cnt_d        = wr_cnt_q;
        wr_req_ready_o  = '0;
        wr_data_ready_o = '0;
        wr_done_o       = '0;
        aw_valid        = 1'b0;
        w_valid         = 1'b0;
        w_data          = '0;
        w_strb          = '0;
        w_last          = 1'b0;
        b_ready         = 1'b0;
        unique case (wr_state_q)
            WIdle: begin
                if (|wr_req_valid_i) begin
                    wr_req_ready_o[wr_pick] = 1'b1;
                    wr_owner_d              = wr_pick;
                    wr_addr_d               = wr_req_addr_i[wr_pick*AW +: AW];
                    wr_len_d                = wr_req_len_i[wr_pick*8 +: 8];
                    wr_ptr_d                = rr_next(wr_pick);
                    wr_cnt_d                = '0;
                    wr_state_d              = WAddr;
                end
            end
            WAddr: begin
                aw_valid = 1'b1;
                if (m_axi.awready) begin
                    wr_state_d = WData;
                end
            end
            WData: begin
                w_valid                     = wr_data_valid_i[wr_owner_q];
                wr_data_ready_o[wr_owner_q] = m_axi.wready;
                w_data                      = wr_data_i[wr_owner_q*DW +: DW];
                w_strb                      = wr_strb_i[wr_owner_q*SW +: SW];
                w_last                      = (wr_cnt_q == wr_len_q);
                if (w_valid && m_axi.wready) begin
                    if (w_last) begin
                        wr_state_d = WResp;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 8'd1;
                    end
                end
            end
            WResp: begin
                b_ready = 1'b1;
                if (m_axi.bvalid) begin
                    wr_done_o[wr_owner_q] = 1'b1;
                    wr_state_d            = WIdle;
                end
            end
            default: wr_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= WIdle;
            wr_owner_q <= '0;
            wr_ptr_q   <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_owner_q <= wr_owner_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign m_axi.awvalid = aw_valid;
    assign m_axi.awaddr  = wr_addr_q;
    assign m_axi.awlen   = wr_len_q;
    assign m_axi.wvalid  = w_valid;
    assign m_axi.wdata   = w_data;
    assign m_axi.wstrb   = w_strb;
    assign m_axi.wlast   = w_last;
    assign m_axi.bready  = b_ready;

endmodule

// File: tb/tb_axi4_port_arbiter.sv
// Bench for axi4_port_arbiter: a reactive AXI slave model, a table of read
// arbitration vectors, and hand-written write/backpressure/concurrency/reset sequences.
module tb_axi4_port_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      rd_req_valid, rd_req_ready, rd_data_valid, rd_data_ready;
    logic [NREQ*AW-1:0]   rd_req_addr, wr_req_addr;
    logic [NREQ*8-1:0]    rd_req_len, wr_req_len;
    logic [DW-1:0]        rd_data;
    logic                 rd_data_last;
    logic [NREQ-1:0]      wr_req_valid, wr_req_ready, wr_data_valid, wr_data_ready, wr_done;
    logic [NREQ*DW-1:0]   wr_data;
    logic [NREQ*SW-1:0]   wr_strb;

    axi4_port_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) ifc ();

    axi4_port_arbiter #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .NUM_REQ           (NREQ)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .rd_req_valid_i (rd_req_valid),
        .rd_req_addr_i  (rd_req_addr),
        .rd_req_len_i   (rd_req_len),
        .rd_req_ready_o (rd_req_ready),
        .rd_data_o      (rd_data),
        .rd_data_valid_o(rd_data_valid),
        .rd_data_last_o (rd_data_last),
        .rd_data_ready_i(rd_data_ready),
        .wr_req_valid_i (wr_req_valid),
        .wr_req_addr_i  (wr_req_addr),
        .wr_req_len_i   (wr_req_len),
        .wr_req_ready_o (wr_req_ready),
        .wr_data_i      (wr_data),
        .wr_strb_i      (wr_strb),
        .wr_data_valid_i(wr_data_valid),
        .wr_data_ready_o(wr_data_ready),
        .wr_done_o      (wr_done),
        .m_axi          (ifc)
    );

    // Per-requester stimulus values, packed onto the DUT buses.
    logic [AW-1:0] rd_addr_v [NREQ];
    logic [7:0]    rd_len_v  [NREQ];
    logic [AW-1:0] wr_addr_v [NREQ];
    logic [7:0]    wr_len_v  [NREQ];
    logic [DW-1:0] wbase     [NREQ];
    logic [SW-1:0] wstrb_v   [NREQ];
    logic [7:0]    wbeat     [NREQ];

    always_comb begin
        rd_req_addr = '0;
        rd_req_len  = '0;
        wr_req_addr = '0;
        wr_req_len  = '0;
        wr_data     = '0;
        wr_strb     = '0;
        for (int r = 0; r < NREQ; r++) begin
            rd_req_addr[r*AW +: AW] = rd_addr_v[r];
            rd_req_len[r*8 +: 8]    = rd_len_v[r];
            wr_req_addr[r*AW +: AW] = wr_addr_v[r];
            wr_req_len[r*8 +: 8]    = wr_len_v[r];
            wr_data[r*DW +: DW]     = wbase[r] + {24'd0, wbeat[r]};
            wr_strb[r*SW +: SW]     = wstrb_v[r];
        end
    end

    // Each requester's write source steps to its next beat on accept.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREQ; r++) wbeat[r] <= 8'd0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (wr_req_ready[r]) wbeat[r] <= 8'd0;
                else if (wr_data_valid[r] && wr_data_ready[r]) wbeat[r] <= wbeat[r] + 8'd1;
            end
        end
    end

    // AXI slave model: rdata = 0xA0000000 | (araddr + beat); B three cycles after wlast.
    logic          arready_en, awready_en, wready_en;
    logic          r_act, b_pend;
    logic [7:0]    r_beat, r_len;
    logic [AW-1:0] r_addr;
    logic [1:0]    b_wait;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_act  <= 1'b0;
            r_beat <= 8'd0;
            r_len  <= 8'd0;
            r_addr <= '0;
            b_pend <= 1'b0;
            b_wait <= 2'd0;
        end else begin
            if (ifc.arvalid && ifc.arready) begin
                r_act  <= 1'b1;
                r_beat <= 8'd0;
                r_addr <= ifc.araddr;
                r_len  <= ifc.arlen;
            end else if (r_act && ifc.rready) begin
                if (r_beat == r_len) r_act <= 1'b0;
                else r_beat <= r_beat + 8'd1;
            end
            if (ifc.wvalid && ifc.wready && ifc.wlast) begin
                b_pend <= 1'b1;
                b_wait <= 2'd2;
            end else if (b_pend && b_wait != 2'd0) begin
                b_wait <= b_wait - 2'd1;
            end
            if (ifc.bvalid && ifc.bready) b_pend <= 1'b0;
        end
    end

    assign ifc.arready = arready_en;
    assign ifc.awready = awready_en;
    assign ifc.wready  = wready_en;
    assign ifc.rvalid  = r_act;
    assign ifc.rdata   = 32'hA000_0000 | (r_addr + {24'd0, r_beat});
    assign ifc.rlast   = r_act && (r_beat == r_len);
    assign ifc.bvalid  = b_pend && (b_wait == 2'd0);

    // Handshake monitors.
    typedef struct { logic [NREQ-1:0] who; logic [DW-1:0] data; logic last; } rbeat_t;
    typedef struct { logic [AW-1:0] addr; logic [7:0] len; int cyc; } areq_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; int cyc; } wbt_t;
    typedef struct { logic [NREQ-1:0] who; int cyc; } done_t;

    rbeat_t          rd_beats [$];
    logic [NREQ-1:0] rd_grants[$];
    areq_t           ar_log   [$];
    areq_t           aw_log   [$];
    wbt_t            w_log    [$];
    done_t           done_log [$];
    int              cyc = 0;
    int              onehot_err = 0;

    always @(posedge clk) begin
        if (rstn) begin
            if (|(rd_data_valid & rd_data_ready))
                rd_beats.push_back('{rd_data_valid, rd_data, rd_data_last});
            if (rd_req_ready != '0) rd_grants.push_back(rd_req_ready);
            if (ifc.arvalid && ifc.arready) ar_log.push_back('{ifc.araddr, ifc.arlen, cyc});
            if (ifc.awvalid && ifc.awready) aw_log.push_back('{ifc.awaddr, ifc.awlen, cyc});
            if (ifc.wvalid && ifc.wready)
                w_log.push_back('{ifc.wdata, ifc.wstrb, ifc.wlast, cyc});
            if (wr_done != '0) done_log.push_back('{wr_done, cyc});
            if (!$onehot0(rd_req_ready) || !$onehot0(rd_data_valid) || !$onehot0(wr_req_ready)
                || !$onehot0(wr_data_ready) || !$onehot0(wr_done))
                onehot_err++;
        end
        cyc++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_rd_beats(input int n);
        for (int i = 0; i < 300 && rd_beats.size() < n; i++) @(negedge clk);
        chk("rd beat count", 64'(rd_beats.size()), 64'(n));
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 300 && done_log.size() < n; i++) @(negedge clk);
        chk("wr_done count", 64'(done_log.size()), 64'(n));
    endtask

    task automatic wait_rd_grant();
        @(negedge clk);
        for (int i = 0; i < 50 && rd_req_ready == '0; i++) @(negedge clk);
    endtask

    task automatic wait_wr_grant();
        @(negedge clk);
        for (int i = 0; i < 50 && wr_req_ready == '0; i++) @(negedge clk);
    endtask

    task automatic chk_rd_beats(input string name, input int base, input int owner,
                                input logic [AW-1:0] addr, input logic [7:0] len);
        for (int k = 0; k <= int'(len); k++) begin
            if (base + k < rd_beats.size()) begin
                chk($sformatf("%s beat%0d owner", name, k), 64'(rd_beats[base+k].who),
                    64'(4'b0001 << owner));
                chk($sformatf("%s beat%0d data", name, k), 64'(rd_beats[base+k].data),
                    64'(32'hA000_0000 | (addr + 32'(k))));
                chk($sformatf("%s beat%0d last", name, k), 64'(rd_beats[base+k].last),
                    64'(k == int'(len)));
            end
        end
    endtask

    task automatic chk_w_beats(input string name, input int base, input int owner,
                               input logic [7:0] len);
        for (int k = 0; k <= int'(len); k++) begin
            if (base + k < w_log.size()) begin
                chk($sformatf("%s w%0d data", name, k), 64'(w_log[base+k].data),
                    64'(wbase[owner] + 32'(k)));
                chk($sformatf("%s w%0d strb", name, k), 64'(w_log[base+k].strb),
                    64'(wstrb_v[owner]));
                chk($sformatf("%s w%0d last", name, k), 64'(w_log[base+k].last),
                    64'(k == int'(len)));
            end
        end
        chk($sformatf("%s w count", name), 64'(w_log.size() - base), 64'(int'(len) + 1));
    endtask

    typedef struct { logic [NREQ-1:0] mask; logic [7:0] len; int exp; } rd_vec_t;
    rd_vec_t tbl [6];

    initial begin
        int rb, gb, wb, db, ab;
        logic [3:0] rr_exp [5];
        // Read arbitration vectors; pointer starts at 0 and moves to grant+1.
        tbl[0] = '{4'b0001, 8'd3, 0};
        tbl[1] = '{4'b1101, 8'd1, 2};
        tbl[2] = '{4'b1001, 8'd0, 3};
        tbl[3] = '{4'b0110, 8'd2, 1};
        tbl[4] = '{4'b0011, 8'd0, 0};
        tbl[5] = '{4'b1000, 8'd1, 3};
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        for (int r = 0; r < NREQ; r++) begin
            rd_addr_v[r] = 32'h100 + 32'(r) * 32'h1000;
            rd_len_v[r]  = 8'd0;
            wr_addr_v[r] = 32'h0;
            wr_len_v[r]  = 8'd0;
            wbase[r]     = 32'h0;
            wstrb_v[r]   = 4'h0;
        end
        arready_en = 1'b1; awready_en = 1'b1; wready_en = 1'b1;
        rd_data_ready = '1; wr_data_valid = '1;
        rd_req_valid = '0;  wr_req_valid = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ctl outputs",
            {rd_req_ready, rd_data_valid, wr_req_ready, wr_data_ready, wr_done, rd_data_last,
             ifc.arvalid, ifc.rready, ifc.awvalid, ifc.wvalid, ifc.wlast, ifc.bready}, 64'd0);
        chk("reset data outputs", {rd_data, ifc.araddr}, 64'd0);
        rstn = 1'b1;

        // Table-driven read arbitration
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            for (int r = 0; r < NREQ; r++) rd_len_v[r] = tbl[t].len;
            rd_req_valid = tbl[t].mask;
            rb = rd_beats.size();
            wait_rd_grant();
            chk($sformatf("vec%0d grant", t), 64'(rd_req_ready), 64'(4'b0001 << tbl[t].exp));
            @(posedge clk); #1;
            rd_req_valid = '0;
            @(negedge clk);
            chk($sformatf("vec%0d arvalid", t), 64'(ifc.arvalid), 64'd1);
            chk($sformatf("vec%0d araddr", t), 64'(ifc.araddr), 64'(rd_addr_v[tbl[t].exp]));
            chk($sformatf("vec%0d arlen", t), 64'(ifc.arlen), 64'(tbl[t].len));
            wait_rd_beats(rb + int'(tbl[t].len) + 1);
            chk_rd_beats($sformatf("vec%0d", t), rb, tbl[t].exp, rd_addr_v[tbl[t].exp],
                         tbl[t].len);
        end

        // Contention: all requesters held high
        @(posedge clk); #1;
        for (int r = 0; r < NREQ; r++) rd_len_v[r] = 8'd0;
        gb = rd_grants.size();
        rb = rd_beats.size();
        rd_req_valid = 4'hF;
        for (int i = 0; i < 200 && rd_grants.size() < gb + 5; i++) @(negedge clk);
        rd_req_valid = '0;
        chk("rr grant count", 64'(rd_grants.size()), 64'(gb + 5));
        wait_rd_beats(rb + 5);
        for (int k = 0; k < 5; k++)
            if (gb + k < rd_grants.size())
                chk($sformatf("rr order %0d", k), 64'(rd_grants[gb+k]), 64'(rr_exp[k]));

        // Single-beat write from requester 2
        @(posedge clk); #1;
        wr_addr_v[2] = 32'h40; wr_len_v[2] = 8'd0; wbase[2] = 32'hDEAD_BEEF; wstrb_v[2] = 4'hF;
        wb = w_log.size(); db = done_log.size(); ab = aw_log.size();
        wr_req_valid = 4'b0100;
        wait_wr_grant();
        chk("wr2 grant", 64'(wr_req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        wr_req_valid = '0;
        wait_done(db + 1);
        if (aw_log.size() > ab)
            chk("wr2 aw addr/len", {aw_log[ab].addr, aw_log[ab].len}, {32'h40, 8'd0});
        chk_w_beats("wr2", wb, 2, 8'd0);
        if (done_log.size() > db && w_log.size() > wb) begin
            chk("wr2 done owner", 64'(done_log[db].who), 64'(4'b0100));
            chk("wr2 done timing", 64'(done_log[db].cyc - w_log[wb].cyc), 64'd3);
        end
        repeat (3) @(negedge clk);
        chk("wr2 done single pulse", 64'(done_log.size()), 64'(db + 1));

        // Backpressure: awready low 5 cycles, wready toggling, len=7
        @(posedge clk); #1;
        wr_addr_v[1] = 32'h200; wr_len_v[1] = 8'd7; wbase[1] = 32'h1111_0000; wstrb_v[1] = 4'h3;
        awready_en = 1'b0;
        wb = w_log.size(); db = done_log.size();
        wr_req_valid = 4'b0010;
        wait_wr_grant();
        chk("bp grant", 64'(wr_req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        wr_req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp aw held %0d", i), {ifc.awvalid, ifc.awaddr, ifc.awlen},
                {1'b1, 32'h200, 8'd7});
        end
        awready_en = 1'b1;
        for (int i = 0; i < 100 && done_log.size() < db + 1; i++) begin
            @(negedge clk);
            wready_en = ~wready_en;
        end
        wready_en = 1'b1;
        wait_done(db + 1);
        chk_w_beats("bp", wb, 1, 8'd7);

        // Concurrent read by requester 1 and write by requester 3
        @(posedge clk); #1;
        for (int r = 0; r < NREQ; r++) rd_len_v[r] = 8'd2;
        wr_addr_v[3] = 32'h300; wr_len_v[3] = 8'd1; wbase[3] = 32'h3333_0000; wstrb_v[3] = 4'h5;
        rb = rd_beats.size(); wb = w_log.size(); db = done_log.size();
        gb = ar_log.size(); ab = aw_log.size();
        rd_req_valid = 4'b0010;
        wr_req_valid = 4'b1000;
        @(negedge clk);
        chk("cc rd grant", 64'(rd_req_ready), 64'(4'b0010));
        chk("cc wr grant", 64'(wr_req_ready), 64'(4'b1000));
        @(posedge clk); #1;
        rd_req_valid = '0;
        wr_req_valid = '0;
        wait_rd_beats(rb + 3);
        wait_done(db + 1);
        if (ar_log.size() > gb && aw_log.size() > ab)
            chk("cc ar/aw same cycle", 64'(ar_log[gb].cyc), 64'(aw_log[ab].cyc));
        chk_rd_beats("cc", rb, 1, rd_addr_v[1], 8'd2);
        chk_w_beats("cc", wb, 3, 8'd1);
        if (done_log.size() > db) chk("cc done owner", 64'(done_log[db].who), 64'(4'b1000));

        // Reset during beat 2 of a 4-beat read
        @(posedge clk); #1;
        for (int r = 0; r < NREQ; r++) rd_len_v[r] = 8'd3;
        rb = rd_beats.size(); db = done_log.size();
        rd_req_valid = 4'b0001;
        wait_rd_grant();
        chk("rst rd grant", 64'(rd_req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        rd_req_valid = '0;
        for (int i = 0; i < 50 && rd_beats.size() < rb + 1; i++) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid-burst reset ctl",
            {rd_req_ready, rd_data_valid, wr_req_ready, wr_data_ready, wr_done, rd_data_last,
             ifc.arvalid, ifc.rready, ifc.awvalid, ifc.wvalid, ifc.wlast, ifc.bready}, 64'd0);
        chk("mid-burst reset rd_data", 64'(rd_data), 64'd0);
        repeat (2) @(negedge clk);
        chk("no beats after reset", 64'(rd_beats.size()), 64'(rb + 1));
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < NREQ; r++) rd_len_v[r] = 8'd1;
        rb = rd_beats.size();
        rd_req_valid = 4'b0011;
        wait_rd_grant();
        chk("post-reset grant ptr0", 64'(rd_req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        rd_req_valid = '0;
        @(negedge clk);
        chk("post-reset araddr", {ifc.arvalid, ifc.araddr, ifc.arlen}, {1'b1, 32'h100, 8'd1});
        wait_rd_beats(rb + 2);
        chk_rd_beats("post-reset", rb, 0, 32'h100, 8'd1);
        chk("no wr_done across reset", 64'(done_log.size()), 64'(db));

        chk("one-hot routing", 64'(onehot_err), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/axi4_port_arbiter.md
Name: axi4_port_arbiter

Overview:
- Shares the single AXI4 full master port of the vector core between NUM_REQ requesters (vector load/store lane groups).
- Independent read and write arbiters, each with round-robin grant and one outstanding burst per direction.
- Drives the AW/W/B/AR/R signals of the core's AXI interface and routes data and completion back to the owning requester.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width (DW)
- NUM_REQ, 4, number of requesters per direction (>=2)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- rd_req_valid  in  NUM_REQ  read burst request per requester
- rd_req_addr  in  NUM_REQ*ADDR_W  packed burst start addresses
- rd_req_len  in  NUM_REQ*8  packed AXI len (beats-1)
- rd_req_ready  out  NUM_REQ  one-hot grant/accept pulse
- rd_data  out  DW  read data, broadcast
- rd_data_valid  out  NUM_REQ  one-hot beat valid to owner
- rd_data_last  out  1  final beat of burst
- rd_data_ready  in  NUM_REQ  owner beat accept
- wr_req_valid / wr_req_addr / wr_req_len / wr_req_ready  as read, write direction
- wr_data  in  NUM_REQ*DW  packed write data
- wr_strb  in  NUM_REQ*DW/8  packed byte strobes
- wr_data_valid  in  NUM_REQ  beat valid from requester
- wr_data_ready  out  NUM_REQ  one-hot beat accept to owner
- wr_done  out  NUM_REQ  one-cycle pulse on B handshake to owner
- m_axi_aw*/w*/b*/ar*/r*  AXI4 master signals (awvalid, awready, awaddr, awlen, wvalid, wready, wdata, wstrb, wlast, bvalid, bready, arvalid, arready, araddr, arlen, rvalid, rready, rdata, rlast), standard directions and widths

Behaviour:
- Reset (async, rstn=0): both FSMs IDLE, round-robin pointers=0, all outputs 0, owner registers cleared. Reset mid-burst aborts silently; no completion pulse.
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: if any rd_req_valid, pick the first set bit searching from rr_ptr upward, with wrap.
  - R_IDLE grant: rd_req_ready[g]=1 combinationally for that one cycle; latch addr/len/owner. Requesters hold valid/addr/len stable until ready.
  - R_ADDR: registered m_axi_arvalid=1 in the cycle after grant, with araddr/arlen from the latches. Held until arready.
  - R_DATA: m_axi_rready = rd_data_ready[owner]. rd_data_valid[owner] = m_axi_rvalid. rd_data = rdata. rd_data_last = rlast.
  - Leave R_DATA on the rvalid&rready&rlast handshake. rr_ptr <= owner+1 mod NUM_REQ at grant.
- Write FSM W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - Grant, latch and AW timing identical to the read side.
  - W_DATA: wvalid = wr_data_valid[owner], wready passed to wr_data_ready[owner], wdata/wstrb muxed from owner.
  - 8-bit beat counter starts at 0 and increments per W handshake. wlast=1 when counter==len. After the last handshake, go to W_RESP.
  - W_RESP: bready=1. On bvalid, pulse wr_done[owner] for 1 cycle and return to W_IDLE. BRESP is not checked.
- Read and write directions are fully independent; simultaneous AR and AW activity is allowed.
- A requester may hold both a read and a write grant at the same time.
- Non-owners always see rd_data_valid=0, wr_data_ready=0, rd_req_ready=0.
- len=0 is a single-beat burst: wlast on the first beat.
- Minimum grant-to-grant spacing per direction: IDLE grant, then AR/AW, data, (resp), then IDLE. No grant is issued in the cycle the FSM returns to IDLE; the next grant is earliest one cycle later.

Test Plan:
- Single read: req0 addr=0x100 len=3, arready=1 -> arvalid 1 cycle after grant, araddr=0x100, arlen=3, 4 beats to owner 0 only, rd_data_last on beat 4.
- Contention: all 4 rd_req_valid held high -> grants in order 0,1,2,3,0. After a grant to 2, the next grant goes to 3 even if 0 is requesting.
- Write len=0 from req2, addr=0x40, data=0xDEADBEEF, strb=0xF -> one W beat with wlast=1, then bvalid after 3 cycles -> wr_done[2] one-cycle pulse.
- Backpressure: awready low for 5 cycles, then wready toggling 1/0 over a len=7 burst -> awvalid held stable; exactly 8 beats with correct data order; wlast only on the 8th.
- Concurrent read by req1 and write by req3 -> AR and AW issued in the same cycle, no cross-routing of data or strobes.
- rstn low during R_DATA beat 2 of 4 -> all outputs 0 immediately. After release, a new req0 read is granted cleanly and rr_ptr restarts at 0.
